gray_frame_writer: RTL and testbench

Consumer end of the grayscale stream. Accepts the valid-qualified 10-bit gray value and black/white flag produced per pixel, buffers them in a small FIFO, and writes one RGB pixel per accepted SDRAM write handshake at a linear frame address. Upstream cannot be stalled, so the FIFO absorbs SDRAM write latency; overflow is flagged, never back-pressured. Sits between the grayscale stage and the SDRAM write port, and closes the read-process-write loop for one frame per start.

---
 rtl/gray_frame_writer_pkg.sv | 26 ++
 rtl/gray_frame_writer_if.sv | 30 +++
 rtl/gray_frame_writer_sync_fifo.sv | 76 +++++++
 rtl/gray_frame_writer.sv | 139 +++++++++++++
 tb/tb_gray_frame_writer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_frame_writer_pkg.sv
// Shared types for the grayscale frame writer: FSM states, pixel payload
// and the gray/black-white to RGB level mapping.
package gray_writer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int PIX_W = 10;
   localparam logic [PIX_W-1:0] WHITE = 10'd1023;

   typedef struct packed {
      logic             bw;
      logic [PIX_W-1:0] color;
   } pix_t;

   // Level driven onto all three colour channels for one buffered pixel.
   function automatic logic [PIX_W-1:0] pix_to_level(input logic bw_mode, input pix_t p);
      if (!bw_mode) return p.color;
      return p.bw ? '0 : WHITE;
   endfunction

endpackage

// File: rtl/gray_frame_writer_if.sv
// Pixel input and SDRAM write port of the frame writer.
// Valid/ready: a pixel is offered when i_valid is high (never back-pressured);
// a write transfers on the cycle o_write_request && i_write_ack, and the
// address/data hold steady while the request waits for its ack.
interface gray_frame_writer_if #(
   parameter int ADDR_W = 19
);
   import gray_writer_pkg::*;

   logic              i_valid;
   logic [PIX_W-1:0]  i_color;
   logic              i_bw;
   logic              o_write_request;
   logic              i_write_ack;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [PIX_W-1:0]  o_red;
   logic [PIX_W-1:0]  o_green;
   logic [PIX_W-1:0]  o_blue;

   modport slave (
      input  i_valid, i_color, i_bw, i_write_ack,
      output o_write_request, o_wr_addr, o_red, o_green, o_blue
   );

   modport master (
      output i_valid, i_color, i_bw, i_write_ack,
      input  o_write_request, o_wr_addr, o_red, o_green, o_blue
   );

endinterface

// File: rtl/gray_frame_writer_sync_fifo.sv
// Synchronous FIFO with a registered head word, async reset and a
// synchronous flush. Push and pop in the same cycle is legal at any fill level.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign o_full  = (count_q == CW'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_head  = head_q;

   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~o_full | do_pop);
   assign rd_nxt  = rd_ptr_q + AW'(1);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   // Head follows whatever becomes the oldest entry after this cycle.
   always_comb begin
      head_d = head_q;
      if (count_q == '0 || (count_q == CW'(1) && do_pop)) begin
         if (do_push) head_d = i_data;
      end else if (do_pop) begin
         head_d = mem_q[rd_nxt];
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_nxt;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

endmodule

// File: rtl/gray_frame_writer.sv
// Buffers per-pixel gray/bw values and writes one RGB pixel per SDRAM write
// handshake at the pixel's own frame index; overflow drops, never stalls.
module gray_frame_writer
   import gray_writer_pkg::*;
#(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 600,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 19
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_bw_mode,
   gray_frame_writer_if.slave    bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overflow,
   output state_t                o_state
);

   localparam int NUM_PIXEL = H_ACTIVE * V_ACTIVE;
   localparam int CNT_W     = $clog2(NUM_PIXEL + 1);
   localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] IN_END  = CNT_W'(NUM_PIXEL);
   localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(NUM_PIXEL - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      pix_t              pix;
   } entry_t;

   state_t            state_q;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic              mode_q;
   logic              busy_q, done_q, overflow_q;

   entry_t            push_entry, head_entry;
   logic              fifo_full, fifo_empty;
   logic [FCW-1:0]    fifo_count;

   logic run, active, request, xfer, take, push, drop, flush;
   logic in_last, last_xfer;
   logic [PIX_W-1:0]  level;

   assign run     = (state_q == S_RUN);
   assign active  = run | (state_q == S_DRAIN);
   assign request = active & ~fifo_empty;
   assign xfer    = request & bus.i_write_ack;
   assign flush   = (state_q == S_IDLE) & i_start;

   // A pixel in its frame slot either enters the FIFO or is dropped; both advance the index.
   assign take     = run & bus.i_valid & (in_cnt_q < IN_END);
   assign push     = take & (~fifo_full | xfer);
   assign drop     = take & ~push;
   assign in_cnt_d = in_cnt_q + CNT_W'(1);

   // Frame ends when every slot has been seen and this transfer empties the FIFO.
   assign in_last   = (in_cnt_q == IN_END) | (take & (in_cnt_q == IN_LAST));
   assign last_xfer = xfer & in_last & (fifo_count == FCW'(1)) & ~push;

   assign push_entry = '{addr: ADDR_W'(in_cnt_q),
                         pix:  '{bw: bus.i_bw, color: bus.i_color}};

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (flush),
      .i_push  (push),
      .i_pop   (xfer),
      .i_data  (push_entry),
      .o_head  (head_entry),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign level               = request ? pix_to_level(mode_q, head_entry.pix) : '0;
   assign bus.o_write_request = request;
   assign bus.o_wr_addr       = request ? head_entry.addr : '0;
   assign bus.o_red           = level;
   assign bus.o_green         = level;
   assign bus.o_blue          = level;

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_overflow = overflow_q;
   assign o_state    = state_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         in_cnt_q   <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_q    <= S_RUN;
                  in_cnt_q   <= '0;
                  overflow_q <= 1'b0;
                  mode_q     <= i_bw_mode;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               if (take) in_cnt_q <= in_cnt_d;
               if (drop) overflow_q <= 1'b1;
               if (last_xfer) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (take && in_cnt_q == IN_LAST) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (last_xfer || fifo_empty) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gray_frame_writer.sv
// Randomized bench for gray_frame_writer on a 4x2 frame with a 4-deep FIFO,
// checked against a queue-based model of the frame/FIFO/handshake rules.
module tb_gray_frame_writer;
   import gray_writer_pkg::*;

   localparam int H     = 4;
   localparam int V     = 2;
   localparam int NPIX  = H * V;
   localparam int DEPTH = 4;
   localparam int AW    = 19;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   start = 1'b0;
   logic   bw_mode = 1'b0;
   logic   busy, done, ovf;
   state_t st;

   gray_frame_writer_if #(.ADDR_W(AW)) bus();

   gray_frame_writer #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (AW)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_bw_mode  (bw_mode),
      .bus        (bus),
      .o_busy     (busy),
      .o_done     (done),
      .o_overflow (ovf),
      .o_state    (st)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: expected FIFO contents {addr, bw, color} plus frame bookkeeping.
   logic [29:0]    exp_q[$];
   bit             m_busy, m_done, m_ovf, m_mode;
   int             m_in;
   bit [NPIX-1:0]  m_pushed, seen_wr;
   int             last_wr, n_wr, n_done, done_base;

   task automatic model_reset();
      exp_q.delete();
      m_busy = 0; m_done = 0; m_ovf = 0; m_mode = 0; m_in = 0;
   endtask

   task automatic cycle(input logic v, input logic [9:0] c, input logic b,
                        input logic a, input logic s);
      logic [29:0] head;
      logic [9:0]  lvl;
      bit          exp_req, pop;
      int          sz;
      bus.i_valid = v; bus.i_color = c; bus.i_bw = b; bus.i_write_ack = a; start = s;
      #1;
      exp_req = m_busy && (exp_q.size() > 0);
      check_eq("req", bus.o_write_request, exp_req);
      if (exp_req) begin
         head = exp_q[0];
         lvl  = m_mode ? (head[10] ? 10'd0 : 10'd1023) : head[9:0];
         check_eq("addr", bus.o_wr_addr, head[29:11]);
         check_eq("red", bus.o_red, lvl);
         check_eq("green", bus.o_green, lvl);
         check_eq("blue", bus.o_blue, lvl);
      end
      if (bus.o_write_request && a) begin
         check_eq("wr_order", int'(bus.o_wr_addr) > last_wr, 1);
         if (bus.o_wr_addr < NPIX) seen_wr[bus.o_wr_addr] = 1'b1;
         last_wr = int'(bus.o_wr_addr);
         n_wr++;
      end
      pop = exp_req && a;
      sz  = exp_q.size();
      if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (s) begin
            m_busy = 1; m_in = 0; m_ovf = 0; m_mode = bw_mode;
            exp_q.delete(); m_pushed = '0;
         end
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (v && m_in < NPIX) begin
            if (sz < DEPTH || pop) begin
               exp_q.push_back({AW'(m_in), b, c});
               m_pushed[m_in] = 1'b1;
            end else begin
               m_ovf = 1;
            end
            m_in++;
         end
         if (m_in == NPIX && exp_q.size() == 0) begin
            m_busy = 0; m_done = 1;
         end
      end
      @(posedge clk); #1;
      check_eq("busy", busy, m_busy);
      check_eq("done", done, m_done);
      check_eq("overflow", ovf, m_ovf);
      if (done) n_done++;
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_valid = 0; bus.i_color = '0; bus.i_bw = 0; bus.i_write_ack = 0; start = 0;
      #2;
      check_eq("rst_req", bus.o_write_request, 0);
      check_eq("rst_addr", bus.o_wr_addr, 0);
      check_eq("rst_rgb", {bus.o_red, bus.o_green, bus.o_blue}, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ovf", ovf, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic start_frame(input logic mode);
      bw_mode   = mode;
      seen_wr   = '0;
      last_wr   = -1;
      n_wr      = 0;
      done_base = n_done;
      cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic finish_frame(input string tag);
      for (int i = 0; i < 100 && (m_busy || m_done); i++) idle_cycle();
      check_eq({tag, "_done_once"}, n_done - done_base, 1);
      check_eq({tag, "_wr_mask"}, seen_wr, m_pushed);
   endtask

   initial begin
      bus.i_valid = 0; bus.i_color = '0; bus.i_bw = 0; bus.i_write_ack = 0;
      n_done = 0; last_wr = -1; n_wr = 0; seen_wr = '0; m_pushed = '0;
      do_reset();

      // Gray mode, ack always high.
      start_frame(1'b0);
      for (int i = 0; i < NPIX; i++) cycle(1'b1, 10'(10 + i), 1'b0, 1'b1, 1'b0);
      finish_frame("gray");
      check_eq("gray_nwr", n_wr, NPIX);
      check_eq("gray_ovf", ovf, 0);

      // Black/white mode, alternating dark/bright pixels.
      start_frame(1'b1);
      for (int i = 0; i < NPIX; i++)
         cycle(1'b1, 10'($urandom_range(0, 1023)), 1'(i % 2 == 0), 1'b1, 1'b0);
      finish_frame("bw");

      // Ack held low for 6 cycles: pixels 4 and 5 are dropped.
      start_frame(1'b0);
      for (int i = 0; i < NPIX; i++)
         cycle(1'b1, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'(i >= 6), 1'b0);
      check_eq("stall_ovf", ovf, 1);
      finish_frame("stall");
      check_eq("stall_mask", seen_wr, 8'hCF);

      // Ack toggling with continuous valid: no loss expected.
      start_frame(1'b0);
      for (int i = 0; i < NPIX; i++)
         cycle(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'(i % 2), 1'b0);
      finish_frame("toggle");
      check_eq("toggle_ovf", ovf, 0);
      check_eq("toggle_nwr", n_wr, NPIX);

      // Restart ignored mid-frame, then reset after three writes.
      start_frame(1'b0);
      for (int i = 0; i < 20 && n_wr < 3; i++)
         cycle(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b1, 1'(i == 1));
      check_eq("midreset_nwr", n_wr, 3);
      done_base = n_done;
      do_reset();
      for (int i = 0; i < 3; i++) idle_cycle();
      check_eq("midreset_nodone", n_done - done_base, 0);
      start_frame(1'b0);
      for (int i = 0; i < NPIX; i++) cycle(1'b1, 10'(100 + i), 1'b0, 1'b1, 1'b0);
      finish_frame("restart");
      check_eq("restart_mask", seen_wr, 8'hFF);

      // Fill the FIFO, then push and pop together while full.
      start_frame(1'b0);
      for (int i = 0; i < NPIX; i++)
         cycle(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'(i >= 4), 1'b0);
      check_eq("full_pp_ovf", ovf, 0);
      finish_frame("full_pp");
      check_eq("full_pp_mask", seen_wr, 8'hFF);

      // Random frames: sparse valid, random ack, random mode.
      for (int f = 0; f < 4; f++) begin
         start_frame(1'($urandom_range(0, 1)));
         for (int i = 0; i < 300 && m_in < NPIX; i++)
            cycle(1'($urandom_range(0, 9) < 7), 10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
         finish_frame("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
